// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// instruction-fetch port and the data-memory port. The data port has
// priority; an instruction request denied MAX_WAIT consecutive cycles is
// force-granted for one cycle. Read responses are steered back to the port
// that issued the read, one cycle after its grant.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   inst_req/we/addr/wdata          instruction-port request (held until ready)
//   inst_ready/rvalid/rdata         instruction-port grant and read response
//   data_req/we/addr/wdata          data-port request (held until ready)
//   data_ready/rvalid/rdata         data-port grant and read response
//   mem_en/we/addr/wdata            SRAM command, driven from the granted port
//   mem_rdata                       SRAM read data, valid one cycle after a read
//
// Optional build macro ARB_PERF_EN adds perf_conflict_cnt (cycles with both
// ports requesting) and perf_force_cnt (starvation-forced instruction grants).
module sram_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [DATA_W/8-1:0] inst_we,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_ready,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_ready,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflict_cnt,
  output logic [31:0]         perf_force_cnt
`endif
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } own_t;

  own_t       resp_own_p1;
  own_t       resp_own_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_nxt;
  logic       force_inst;
  logic       grant_inst;
  logic       grant_data;

  // Grants are gated by resetn so every output is quiet while in reset.
  always_comb begin
    force_inst = inst_req && (wait_cnt == WAIT_LIMIT);
    grant_inst = resetn && inst_req && (!data_req || force_inst);
    grant_data = resetn && data_req && !grant_inst;
  end

  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_inst) begin
      mem_we    = inst_we;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end else if (grant_data) begin
      mem_we    = data_we;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  assign mem_en     = grant_inst || grant_data;
  assign inst_ready = grant_inst;
  assign data_ready = grant_data;

  // Only reads produce a response; writes leave the response slot empty.
  always_comb begin
    resp_own_nxt = OWN_NONE;
    if (grant_inst && (inst_we == '0)) begin
      resp_own_nxt = OWN_INST;
    end else if (grant_data && (data_we == '0)) begin
      resp_own_nxt = OWN_DATA;
    end
  end

  // Denial streak of a pending instruction request, saturating at the limit.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!inst_req || grant_inst) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt_nxt = wait_cnt + 4'd1;
    end
  end

  // Stage p0 -> p1: grant decision registered as response owner.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_own_p1 <= OWN_NONE;
      wait_cnt    <= '0;
    end else begin
      resp_own_p1 <= resp_own_nxt;
      wait_cnt    <= wait_cnt_nxt;
    end
  end

  assign inst_rvalid = (resp_own_p1 == OWN_INST);
  assign data_rvalid = (resp_own_p1 == OWN_DATA);
  assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
  assign data_rdata  = data_rvalid ? mem_rdata : '0;

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_conflict_cnt <= '0;
      perf_force_cnt    <= '0;
    end else begin
      if (inst_req && data_req) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
      if (grant_inst && force_inst) begin
        perf_force_cnt <= perf_force_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_sram_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;
  localparam int BE_W     = DATA_W / 8;
  localparam logic [31:0] AMASK = 32'hFFFF_FC7C;

  logic              clk = 1'b0;
  logic              resetn;
  logic              inst_req, data_req;
  logic [BE_W-1:0]   inst_we, data_we;
  logic [ADDR_W-1:0] inst_addr, data_addr;
  logic [DATA_W-1:0] inst_wdata, data_wdata;
  logic              inst_ready, inst_rvalid, data_ready, data_rvalid;
  logic [DATA_W-1:0] inst_rdata, data_rdata;
  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef ARB_PERF_EN
  logic [31:0]       perf_conflict_cnt, perf_force_cnt;
`endif

  int tests = 0;
  int fails = 0;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_ready(inst_ready), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt), .perf_force_cnt(perf_force_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM macro model: 1-cycle read latency, junk on the read bus otherwise.
  bit [31:0] sram [256];
  always @(posedge clk) begin
    if (mem_en && (mem_we == '0)) begin
      mem_rdata <= sram[mem_addr[9:2]];
    end else begin
      mem_rdata <= $urandom;
      if (mem_en) begin
        for (int b = 0; b < BE_W; b++) begin
          if (mem_we[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reference model state.
  bit [31:0]   ref_mem [256];
  int          streak, own_q, nx_own, cnt_conflict, cnt_force;
  logic [31:0] rdata_q, nx_rdata;
  bit          starving, e_ig, e_dg, e_en, e_irv, e_drv;
  logic [3:0]  e_we;
  logic [31:0] e_addr, e_wdata, e_ird, e_drd;

  task automatic model_reset();
    streak = 0; own_q = 0; rdata_q = '0; cnt_conflict = 0; cnt_force = 0;
  endtask

  task automatic model_eval();
    starving = resetn && inst_req && (streak >= MAX_WAIT);
    e_ig = resetn && inst_req && (!data_req || starving);
    e_dg = resetn && data_req && !e_ig;
    e_en = e_ig || e_dg;
    e_we = '0; e_addr = '0; e_wdata = '0;
    if (e_ig) begin
      e_we = inst_we; e_addr = inst_addr; e_wdata = inst_wdata;
    end else if (e_dg) begin
      e_we = data_we; e_addr = data_addr; e_wdata = data_wdata;
    end
    e_irv = (own_q == 1);
    e_drv = (own_q == 2);
    e_ird = e_irv ? rdata_q : '0;
    e_drd = e_drv ? rdata_q : '0;
    nx_own = 0;
    if (e_en && (e_we == '0)) nx_own = e_ig ? 1 : 2;
    nx_rdata = ref_mem[e_addr[9:2]];
  endtask

  task automatic model_commit();
    if (!resetn) begin
      model_reset();
    end else begin
      if (e_en && (e_we != '0)) begin
        for (int b = 0; b < BE_W; b++)
          if (e_we[b]) ref_mem[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
      end
      if (inst_req && data_req) cnt_conflict++;
      if (e_ig && starving) cnt_force++;
      if (inst_req && !e_ig) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
      else streak = 0;
      own_q = nx_own;
      rdata_q = nx_rdata;
    end
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_we = '0; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_we = '0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 0;
    model_reset();
    advance();
    advance();
    resetn = 1;
  endtask

  task automatic test_reset();
    resetn = 0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      inst_req = 1; inst_we = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      data_req = 1; data_we = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      settle();
      tests++;
      if ({inst_ready, data_ready, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
        fails++;
        $display("FAIL reset_cmd: got rdy=%b%b en=%b we=%h addr=%h wdata=%h expected all 0",
                 inst_ready, data_ready, mem_en, mem_we, mem_addr, mem_wdata);
      end
      tests++;
      if ({inst_rvalid, data_rvalid, inst_rdata, data_rdata} !== '0) begin
        fails++;
        $display("FAIL reset_resp: got rv=%b%b ird=%h drd=%h expected all 0",
                 inst_rvalid, data_rvalid, inst_rdata, data_rdata);
      end
`ifdef ARB_PERF_EN
      tests++;
      if ({perf_conflict_cnt, perf_force_cnt} !== '0) begin
        fails++;
        $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_conflict_cnt, perf_force_cnt);
      end
`endif
      advance();
    end
    idle_inputs();
    resetn = 1;
    advance();
  endtask

  task automatic test_inst_read();
    data_req = 1; data_we = 4'hF; data_addr = 32'h1C00_0000; data_wdata = 32'h0000_0013;
    settle();
    tests++;
    if (data_ready !== 1'b1) begin
      fails++; $display("FAIL preload_ready: got %b expected 1", data_ready);
    end
    advance();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0000;
    settle();
    tests++;
    if ({inst_ready, mem_en, data_ready} !== 3'b110) begin
      fails++;
      $display("FAIL inst_grant: got ready=%b en=%b dready=%b expected 1 1 0", inst_ready, mem_en, data_ready);
    end
    tests++;
    if (mem_addr !== 32'h1C00_0000 || mem_we !== 4'h0) begin
      fails++; $display("FAIL inst_cmd: got addr=%h we=%h expected 1c000000 0", mem_addr, mem_we);
    end
    advance();
    idle_inputs();
    settle();
    tests++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h0000_0013 || data_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL inst_resp: got rv=%b rdata=%h drv=%b expected 1 00000013 0", inst_rvalid, inst_rdata, data_rvalid);
    end
    advance();
  endtask

  task automatic test_data_write();
    data_req = 1; data_we = 4'b0011; data_addr = 32'h100; data_wdata = 32'hAABB_CCDD;
    settle();
    tests++;
    if (data_ready !== 1'b1 || inst_ready !== 1'b0 || mem_en !== 1'b1) begin
      fails++; $display("FAIL dwr_grant: got dready=%b iready=%b en=%b expected 1 0 1", data_ready, inst_ready, mem_en);
    end
    tests++;
    if (mem_we !== 4'b0011 || mem_wdata !== 32'hAABB_CCDD || mem_addr !== 32'h100) begin
      fails++;
      $display("FAIL dwr_cmd: got we=%b wdata=%h addr=%h expected 0011 aabbccdd 00000100", mem_we, mem_wdata, mem_addr);
    end
    advance();
    idle_inputs();
    data_req = 1; data_addr = 32'h100;
    settle();
    tests++;
    if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin
      fails++; $display("FAIL dwr_no_rvalid: got %b%b expected 00", inst_rvalid, data_rvalid);
    end
    advance();
    idle_inputs();
    settle();
    tests++;
    if (data_rvalid !== 1'b1 || data_rdata !== 32'h0000_CCDD) begin
      fails++; $display("FAIL dwr_readback: got rv=%b rdata=%h expected 1 0000ccdd", data_rvalid, data_rdata);
    end
    advance();
  endtask

  task automatic test_alternate();
    logic [31:0] val [9];
    for (int i = 1; i <= 8; i++) begin
      val[i] = $urandom;
      idle_inputs();
      data_req = 1; data_we = 4'hF; data_addr = 32'(4 * i); data_wdata = val[i];
      settle();
      tests++;
      if (data_ready !== 1'b1) begin
        fails++; $display("FAIL alt_fill_%0d: got %b expected 1", i, data_ready);
      end
      advance();
    end
    for (int k = 0; k <= 8; k++) begin
      idle_inputs();
      if (k < 8) begin
        if (k % 2 == 0) begin data_req = 1; data_addr = 32'(4 * (k + 1)); end
        else begin inst_req = 1; inst_addr = 32'(4 * (k + 1)); end
      end
      settle();
      if (k < 8) begin
        tests++;
        if ({data_ready, inst_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          fails++; $display("FAIL alt_grant_%0d: got d%b i%b", k, data_ready, inst_ready);
        end
      end
      if (k > 0) begin
        tests++;
        if ((k - 1) % 2 == 0) begin
          if (data_rvalid !== 1'b1 || inst_rvalid !== 1'b0 || data_rdata !== val[k]) begin
            fails++;
            $display("FAIL alt_resp_%0d: got drv=%b irv=%b drd=%h expected 1 0 %h", k, data_rvalid, inst_rvalid, data_rdata, val[k]);
          end
        end else begin
          if (inst_rvalid !== 1'b1 || data_rvalid !== 1'b0 || inst_rdata !== val[k]) begin
            fails++;
            $display("FAIL alt_resp_%0d: got irv=%b drv=%b ird=%h expected 1 0 %h", k, inst_rvalid, data_rvalid, inst_rdata, val[k]);
          end
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    bit exp_i, prev_i;
    do_reset();
    prev_i = 0;
    for (int c = 0; c < 10; c++) begin
      inst_req = 1; data_req = 1; inst_we = '0; data_we = '0;
      if (c == 0 || prev_i) inst_addr = 32'h1C00_0000 | 32'(4 * (c + 2));
      if (c == 0 || !prev_i) data_addr = 32'(4 * ((c % 8) + 1));
      settle();
      exp_i = (c == 4 || c == 9);
      tests++;
      if (inst_ready !== exp_i || data_ready !== !exp_i) begin
        fails++; $display("FAIL cont_grant_%0d: got i%b d%b expected i%b d%b", c, inst_ready, data_ready, exp_i, !exp_i);
      end
      tests++;
      if (inst_rvalid !== (c == 5) || data_rvalid !== (c > 0 && c != 5)) begin
        fails++; $display("FAIL cont_rvalid_%0d: got i%b d%b", c, inst_rvalid, data_rvalid);
      end
      tests++;
      if (inst_rdata !== e_ird || data_rdata !== e_drd) begin
        fails++; $display("FAIL cont_rdata_%0d: got %h/%h expected %h/%h", c, inst_rdata, data_rdata, e_ird, e_drd);
      end
      prev_i = exp_i;
      advance();
    end
    idle_inputs();
    settle();
    tests++;
    if (inst_rvalid !== 1'b1 || data_rvalid !== 1'b0 || inst_rdata !== e_ird) begin
      fails++; $display("FAIL cont_tail: got irv=%b drv=%b ird=%h expected 1 0 %h", inst_rvalid, data_rvalid, inst_rdata, e_ird);
    end
    advance();
`ifdef ARB_PERF_EN
    tests++;
    if (perf_conflict_cnt !== 32'd10 || perf_force_cnt !== 32'd2) begin
      fails++; $display("FAIL cont_perf: got %0d/%0d expected 10/2", perf_conflict_cnt, perf_force_cnt);
    end
`endif
  endtask

  task automatic test_random();
    bit need_i, need_d;
    need_i = 1; need_d = 1;
    for (int c = 0; c < 300; c++) begin
      if (need_i) begin
        inst_req = ($urandom_range(0, 3) != 0);
        inst_we = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        inst_addr = $urandom & AMASK; inst_wdata = $urandom;
      end
      if (need_d) begin
        data_req = ($urandom_range(0, 3) != 0);
        data_we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        data_addr = $urandom & AMASK; data_wdata = $urandom;
      end
      settle();
      tests++;
      if (inst_ready !== e_ig || data_ready !== e_dg || mem_en !== e_en) begin
        fails++;
        $display("FAIL rnd_grant_%0d: got i%b d%b en%b expected i%b d%b en%b", c, inst_ready, data_ready, mem_en, e_ig, e_dg, e_en);
      end
      tests++;
      if (mem_we !== e_we || mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        fails++;
        $display("FAIL rnd_cmd_%0d: got %h %h %h expected %h %h %h", c, mem_we, mem_addr, mem_wdata, e_we, e_addr, e_wdata);
      end
      tests++;
      if (inst_rvalid !== e_irv || data_rvalid !== e_drv || inst_rdata !== e_ird || data_rdata !== e_drd) begin
        fails++;
        $display("FAIL rnd_resp_%0d: got %b%b %h %h expected %b%b %h %h", c, inst_rvalid, data_rvalid,
                 inst_rdata, data_rdata, e_irv, e_drv, e_ird, e_drd);
      end
      need_i = !inst_req || e_ig;
      need_d = !data_req || e_dg;
      advance();
    end
    idle_inputs();
    advance();
`ifdef ARB_PERF_EN
    tests++;
    if (perf_conflict_cnt !== 32'(cnt_conflict) || perf_force_cnt !== 32'(cnt_force)) begin
      fails++;
      $display("FAIL rnd_perf: got %0d/%0d expected %0d/%0d", perf_conflict_cnt, perf_force_cnt, cnt_conflict, cnt_force);
    end
`endif
  endtask

  task automatic test_reset_inflight();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1C00_0000;
    settle();
    tests++;
    if (inst_ready !== 1'b1) begin
      fails++; $display("FAIL rif_grant: got %b expected 1", inst_ready);
    end
    @(posedge clk);
    model_commit();
    #1;
    resetn = 0;
    model_reset();
    @(negedge clk);
    inst_req = 1; data_req = 1;
    settle();
    tests++;
    if (inst_rvalid !== 1'b0 || inst_rdata !== '0) begin
      fails++; $display("FAIL rif_rvalid_in_reset: got %b %h expected 0 0", inst_rvalid, inst_rdata);
    end
    tests++;
    if ({inst_ready, data_ready, mem_en, mem_we, mem_addr, mem_wdata, data_rvalid} !== '0) begin
      fails++; $display("FAIL rif_outputs: got rdy=%b%b en=%b addr=%h expected 0", inst_ready, data_ready, mem_en, mem_addr);
    end
    advance();
    idle_inputs();
    resetn = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      tests++;
      if (inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin
        fails++; $display("FAIL rif_after_%0d: got %b%b expected 00", c, inst_rvalid, data_rvalid);
      end
      advance();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    resetn = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_inst_read();
    test_data_write();
    test_alternate();
    test_contention();
    test_random();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
